// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key event scheduler: key FSM encoding,
// event type values and a constant-friendly clog2 helper.
package key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_t;

  localparam logic EVT_SHORT = 1'b0;
  localparam logic EVT_LONG  = 1'b1;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input longint value);
    int result;
    result = 0;
    for (int i = 0; i < 63; i++) begin
      if ((longint'(1) << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// so the first requester at or after ptr wins.
module rr_arbiter
  import key_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2(longint'(N))
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW:0] cand;

  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so ptr+k can be folded back into 0..N-1 without a divider.
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      if (!gnt_any && req[cand[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    gnt = gnt_any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/key_led_sched.sv
// Classifies debounced key presses as short/long, queues them as pending
// events and serves one per cycle round-robin into per-key LED state.
module key_led_sched
  import key_sched_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int LONG_CNT   = 50000000,
  parameter int BLINK_HALF = 12500000,
  localparam int KW = clog2(longint'(NUM_KEYS))
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] led,
  output logic                evt_valid,
  output logic [KW-1:0]       evt_key,
  output logic                evt_long
);

  localparam int CW     = clog2(longint'(LONG_CNT) + 1);
  localparam int BW_RAW = clog2(longint'(BLINK_HALF));
  localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;

  logic [NUM_KEYS-1:0] post, post_long;
  logic [NUM_KEYS-1:0] pend_reg, pend_next;
  logic [NUM_KEYS-1:0] pend_long_reg, pend_long_next;
  logic [NUM_KEYS-1:0] level_reg, level_next;
  logic [NUM_KEYS-1:0] blink_en_reg, blink_en_next;
  logic [NUM_KEYS-1:0] led_next;
  logic [KW-1:0]       ptr_reg, ptr_next;
  logic [BW-1:0]       blink_cnt_reg, blink_cnt_next;
  logic                phase_reg, phase_next;
  logic                blink_wrap;

  logic [NUM_KEYS-1:0] gnt;
  logic [KW-1:0]       gnt_idx;
  logic                gnt_any;

  // Per-key press classifier; key_state is only trusted when key_flag pulses.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_state_t    state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          post_key, post_key_long;

    always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      post_key      = 1'b0;
      post_key_long = EVT_SHORT;
      case (state_reg)
        IDLE: begin
          if (key_flag[gi] && !key_state[gi]) begin
            state_next = HELD;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (key_flag[gi] && key_state[gi]) begin
            state_next    = IDLE;
            post_key      = 1'b1;
            post_key_long = EVT_SHORT;
          end else if (cnt_reg == CW'(LONG_CNT - 1)) begin
            state_next    = LONG;
            post_key      = 1'b1;
            post_key_long = EVT_LONG;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        LONG: begin
          // A long event was already posted; the release is silent.
          if (key_flag[gi] && key_state[gi]) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
      end
    end

    assign post[gi]      = post_key;
    assign post_long[gi] = post_key_long;
  end

  rr_arbiter #(
    .N(NUM_KEYS)
  ) u_arb (
    .req    (pend_reg),
    .ptr    (ptr_reg),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );

  always_comb begin
    // A post on the grant edge re-arms the slot with the newer event type.
    pend_next      = (pend_reg & ~gnt) | post;
    pend_long_next = (pend_long_reg & ~post) | (post_long & post);
    level_next     = level_reg ^ (gnt & ~pend_long_reg);
    blink_en_next  = blink_en_reg ^ (gnt & pend_long_reg);

    ptr_next = ptr_reg;
    if (gnt_any) begin
      ptr_next = (gnt_idx == KW'(NUM_KEYS - 1)) ? '0 : gnt_idx + KW'(1);
    end

    blink_wrap     = (blink_cnt_reg == BW'(BLINK_HALF - 1));
    blink_cnt_next = blink_wrap ? '0 : blink_cnt_reg + BW'(1);
    phase_next     = phase_reg ^ blink_wrap;

    // Built from next-state values so led moves on the same edge as evt_valid.
    led_next = (blink_en_next & {NUM_KEYS{phase_next}}) | (~blink_en_next & level_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg      <= '0;
      pend_long_reg <= '0;
      level_reg     <= '0;
      blink_en_reg  <= '0;
      ptr_reg       <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      led           <= '0;
      evt_valid     <= 1'b0;
      evt_key       <= '0;
      evt_long      <= 1'b0;
    end else begin
      pend_reg      <= pend_next;
      pend_long_reg <= pend_long_next;
      level_reg     <= level_next;
      blink_en_reg  <= blink_en_next;
      ptr_reg       <= ptr_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
      led           <= led_next;
      evt_valid     <= gnt_any;
      if (gnt_any) begin
        evt_key  <= gnt_idx;
        evt_long <= pend_long_reg[gnt_idx];
      end
    end
  end

endmodule

// File: tb/tb_key_led_sched.sv
// Directed bench for key_led_sched with short timing constants so long
// presses and blinking fit in a few hundred cycles.
module tb_key_led_sched;

  localparam int NK = 4;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_flag;
  logic [NK-1:0] key_state;
  logic [NK-1:0] led;
  logic          evt_valid;
  logic [1:0]    evt_key;
  logic          evt_long;

  int total;
  int bad;

  key_led_sched #(
    .NUM_KEYS  (NK),
    .LONG_CNT  (100),
    .BLINK_HALF(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_flag (key_flag),
    .key_state(key_state),
    .led      (led),
    .evt_valid(evt_valid),
    .evt_key  (evt_key),
    .evt_long (evt_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle flag on the keys in m; rel gives their new level (1 = released).
  task automatic flag(input logic [NK-1:0] m, input logic [NK-1:0] rel);
    key_state = (key_state & ~m) | (rel & m);
    key_flag  = m;
    step(1);
    key_flag  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (led !== 4'b0000) begin bad++; $display("FAIL reset_led: got %b want 0000", led); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    total++; if (evt_key !== 2'd0) begin bad++; $display("FAIL reset_evt_key: got %0d want 0", evt_key); end
    total++; if (evt_long !== 1'b0) begin bad++; $display("FAIL reset_evt_long: got %b want 0", evt_long); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_short_press();
    flag(4'b0001, 4'b0000);
    step(19);
    flag(4'b0001, 4'b0001);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL short_latency_early: got %b want 0", evt_valid); end
    step(1);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL short_evt_valid: got %b want 1", evt_valid); end
    total++; if (evt_key !== 2'd0) begin bad++; $display("FAIL short_evt_key: got %0d want 0", evt_key); end
    total++; if (evt_long !== 1'b0) begin bad++; $display("FAIL short_evt_long: got %b want 0", evt_long); end
    total++; if (led !== 4'b0001) begin bad++; $display("FAIL short_led_on: got %b want 0001", led); end
    step(1);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL short_pulse_width: got %b want 0", evt_valid); end
    total++; if (evt_key !== 2'd0) begin bad++; $display("FAIL short_key_hold: got %0d want 0", evt_key); end
    flag(4'b0001, 4'b0000);
    step(19);
    flag(4'b0001, 4'b0001);
    step(1);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL short2_evt_valid: got %b want 1", evt_valid); end
    total++; if (led !== 4'b0000) begin bad++; $display("FAIL short2_led_off: got %b want 0000", led); end
    step(1);
  endtask

  task automatic test_long_press();
    int seen, ntr, last, gaps_bad, lit;
    logic prev;
    seen = 0;
    flag(4'b0010, 4'b0000);
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL long_early_events: got %0d want 0", seen); end
    step(1);
    total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL long_evt_valid: got %b want 1", evt_valid); end
    total++; if (evt_key !== 2'd1) begin bad++; $display("FAIL long_evt_key: got %0d want 1", evt_key); end
    total++; if (evt_long !== 1'b1) begin bad++; $display("FAIL long_evt_long: got %b want 1", evt_long); end
    prev = led[1]; ntr = 0; last = -1; gaps_bad = 0; seen = 0;
    for (int i = 1; i <= 48; i++) begin
      step(1);
      if (evt_valid) seen++;
      if (led[1] !== prev) begin
        if (last >= 0 && (i - last) != 10) gaps_bad++;
        last = i;
        ntr++;
        prev = led[1];
      end
    end
    total++; if (ntr < 4) begin bad++; $display("FAIL blink_toggles: got %0d want >=4", ntr); end
    total++; if (gaps_bad !== 0) begin bad++; $display("FAIL blink_period: got %0d bad gaps want 0", gaps_bad); end
    total++; if (led[0] !== 1'b0) begin bad++; $display("FAIL blink_other_led: got %b want 0", led[0]); end
    flag(4'b0010, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL long_release_silent: got %0d events want 0", seen); end
    flag(4'b0010, 4'b0000);
    step(100);
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd1 || evt_long !== 1'b1) begin
      bad++; $display("FAIL long2_event: got v=%b k=%0d l=%b want v=1 k=1 l=1", evt_valid, evt_key, evt_long);
    end
    lit = 0;
    for (int i = 0; i < 25; i++) begin
      if (led[1] !== 1'b0) lit++;
      step(1);
    end
    total++; if (lit !== 0) begin bad++; $display("FAIL blink_off_level: got %0d lit cycles want 0", lit); end
    flag(4'b0010, 4'b0010);
    step(2);
  endtask

  task automatic test_contention();
    flag(4'b0001, 4'b0000);
    step(2);
    flag(4'b0001, 4'b0001);
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
      bad++; $display("FAIL cont_setup: got v=%b k=%0d want v=1 k=0", evt_valid, evt_key);
    end
    step(1);
    flag(4'b1101, 4'b0000);
    step(5);
    flag(4'b1101, 4'b1101);
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd2) begin
      bad++; $display("FAIL cont_first: got v=%b k=%0d want v=1 k=2", evt_valid, evt_key);
    end
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd3) begin
      bad++; $display("FAIL cont_second: got v=%b k=%0d want v=1 k=3", evt_valid, evt_key);
    end
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd0 || evt_long !== 1'b0) begin
      bad++; $display("FAIL cont_third: got v=%b k=%0d l=%b want v=1 k=0 l=0", evt_valid, evt_key, evt_long);
    end
    step(1);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL cont_done: got %b want 0", evt_valid); end
    total++; if (led !== 4'b1100) begin bad++; $display("FAIL cont_led: got %b want 1100", led); end
    flag(4'b0011, 4'b0000);
    step(3);
    flag(4'b0011, 4'b0011);
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd1) begin
      bad++; $display("FAIL cont_ptr_first: got v=%b k=%0d want v=1 k=1", evt_valid, evt_key);
    end
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
      bad++; $display("FAIL cont_ptr_second: got v=%b k=%0d want v=1 k=0", evt_valid, evt_key);
    end
    step(1);
    total++; if (led !== 4'b1111) begin bad++; $display("FAIL cont_led_all: got %b want 1111", led); end
  endtask

  task automatic test_ignored();
    int seen;
    seen = 0;
    flag(4'b0010, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL ign_idle_release: got %0d events want 0", seen); end
    flag(4'b0010, 4'b0000);
    step(29);
    flag(4'b0010, 4'b0000);
    for (int i = 0; i < 70; i++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL ign_held_press: got %0d events want 0", seen); end
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd1 || evt_long !== 1'b1) begin
      bad++; $display("FAIL ign_long_timing: got v=%b k=%0d l=%b want v=1 k=1 l=1", evt_valid, evt_key, evt_long);
    end
    flag(4'b0010, 4'b0010);
    step(3);
  endtask

  task automatic test_overwrite();
    int seen;
    seen = 0;
    flag(4'b0100, 4'b0000);
    step(2);
    flag(4'b0100, 4'b0100);
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd2) begin
      bad++; $display("FAIL ovw_setup: got v=%b k=%0d want v=1 k=2", evt_valid, evt_key);
    end
    step(2);
    flag(4'b0100, 4'b0000);
    flag(4'b1001, 4'b0000);
    for (int i = 0; i < 98; i++) begin
      step(1);
      if (evt_valid) seen++;
    end
    flag(4'b1001, 4'b1001);
    total++; if (seen !== 0 || evt_valid !== 1'b0) begin
      bad++; $display("FAIL ovw_quiet: got %0d events v=%b want 0 events v=0", seen, evt_valid);
    end
    flag(4'b0100, 4'b0100);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd3 || evt_long !== 1'b0) begin
      bad++; $display("FAIL ovw_key3: got v=%b k=%0d l=%b want v=1 k=3 l=0", evt_valid, evt_key, evt_long);
    end
    flag(4'b0100, 4'b0000);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
      bad++; $display("FAIL ovw_key0: got v=%b k=%0d want v=1 k=0", evt_valid, evt_key);
    end
    flag(4'b0100, 4'b0100);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd2 || evt_long !== 1'b1) begin
      bad++; $display("FAIL ovw_key2_long: got v=%b k=%0d l=%b want v=1 k=2 l=1", evt_valid, evt_key, evt_long);
    end
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd2 || evt_long !== 1'b0) begin
      bad++; $display("FAIL ovw_key2_new: got v=%b k=%0d l=%b want v=1 k=2 l=0", evt_valid, evt_key, evt_long);
    end
    step(1);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL ovw_drained: got %b want 0", evt_valid); end
  endtask

  task automatic test_reset_mid_hold();
    int seen;
    seen = 0;
    flag(4'b1001, 4'b0000);
    step(58);
    flag(4'b0001, 4'b0001);
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
      bad++; $display("FAIL rst_pre_event: got v=%b k=%0d want v=1 k=0", evt_valid, evt_key);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_async_evt: got %b want 0", evt_valid); end
    total++; if (led !== 4'b0000) begin bad++; $display("FAIL rst_async_led: got %b want 0000", led); end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_long: got %0d events want 0", seen); end
    total++; if (led !== 4'b0000) begin bad++; $display("FAIL rst_led_stays: got %b want 0000", led); end
    flag(4'b1000, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_release_ignored: got %0d events want 0", seen); end
    flag(4'b1000, 4'b0000);
    step(2);
    flag(4'b1000, 4'b1000);
    step(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 2'd3 || evt_long !== 1'b0) begin
      bad++; $display("FAIL rst_fresh_press: got v=%b k=%0d l=%b want v=1 k=3 l=0", evt_valid, evt_key, evt_long);
    end
    total++; if (led !== 4'b1000) begin bad++; $display("FAIL rst_fresh_led: got %b want 1000", led); end
    step(2);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    key_flag  = '0;
    key_state = '1;
    test_reset();
    test_short_press();
    test_long_press();
    test_contention();
    test_ignored();
    test_overwrite();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_led_sched.md
Name: key_led_sched

Overview:
- Event scheduler that sits between NUM_KEYS debounced-key blocks and the board LEDs.
- Classifies each key press as short or long and queues the resulting events as pending.
- Serves pending events to the single LED update path with round-robin arbitration, one event per cycle.
- Per-key LED state: short press toggles the steady level; long press toggles blink mode.

Parameters:
NUM_KEYS, 4, number of key channels and LEDs
LONG_CNT, 50000000, hold duration in clk cycles that qualifies a press as long (1 s at 50 MHz)
BLINK_HALF, 12500000, blink half-period in clk cycles (shared by all LEDs)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, asynchronous, active-low
key_flag  in  NUM_KEYS  one-cycle pulse from the debouncer when key i changes debounced state
key_state  in  NUM_KEYS  debounced level; 0 = pressed, 1 = released; sampled only when key_flag[i]=1
led  out  NUM_KEYS  LED drive, 1 = on
evt_valid  out  1  one-cycle pulse, an event was served this cycle
evt_key  out  $clog2(NUM_KEYS)  index of the served key
evt_long  out  1  1 = long event, 0 = short event

Behaviour:
- Reset (asynchronous): all outputs 0. Key FSMs go to IDLE. Hold counters, pend, pend_long, arbiter pointer, blink counter, blink phase, steady levels and blink enables all clear to 0.
- Per-key FSM, states IDLE / HELD / LONG:
  - IDLE: flag with state=0 -> HELD, hold counter = 0. Flag with state=1 is ignored.
  - HELD: counter increments each cycle. When counter reaches LONG_CNT-1 -> LONG and post a long event. Flag with state=1 -> IDLE and post a short event. Flag with state=0 is ignored.
  - LONG: flag with state=1 -> IDLE, no event. The counter holds.
  - Counter width: $clog2(LONG_CNT+1). It never wraps.
- Posting: an event sets pend[i] and writes pend_long[i] on the edge after the flag or counter condition. If the key is already pending, the newest event type overwrites the old one (newest wins).
- Arbiter:
  - Combinational round-robin over pend, starting the search at pointer ptr.
  - At most one grant g per cycle.
  - On the grant edge: pend[g] clears, and ptr = (g+1) mod NUM_KEYS.
  - If a new event posts for g on the same edge, the new event wins: pend[g] stays 1 with the new type.
  - No pend bits set -> no grant, ptr holds.
- Action, registered on the grant edge:
  - evt_valid=1, evt_key=g, evt_long=pend_long[g].
  - Short event: level[g] inverts.
  - Long event: blink_en[g] inverts.
  - evt_valid is 0 in every non-grant cycle. evt_key and evt_long hold their last values.
- Latency: flag sampled at edge t0 -> pend set after t0 -> led and evt_valid updated after t1=t0+1. Under contention the extra delay is at most NUM_KEYS-1 cycles.
- Blink:
  - A free-running counter counts 0..BLINK_HALF-1; phase inverts at wrap.
  - led[i] = blink_en[i] ? phase : level[i].
  - Turning blink off restores led to level[i] on the next cycle.
  - led is registered.
- Reset mid-operation: a key still physically held after reset stays IDLE until the next press flag. No long event is generated from a pre-reset hold.

Decomposition:
- Package key_sched_pkg holds:
  - key FSM state encoding (IDLE=2'd0, HELD=2'd1, LONG=2'd2)
  - event type constants EVT_SHORT=1'b0, EVT_LONG=1'b1
  - the clog2 helper
- Sub-module rr_arbiter:
  - parameter N
  - inputs req[N], ptr; outputs gnt (one-hot), gnt_idx, gnt_any
  - purely combinational
  - key_led_sched owns the ptr register.

Test Plan (sim overrides: NUM_KEYS=4, LONG_CNT=100, BLINK_HALF=10):
- Short press: key0 press flag, release flag 20 cycles later -> evt_valid pulse 2 edges after the release flag, evt_key=0, evt_long=0, led[0] 0->1. Repeat -> led[0] 1->0.
- Long press: hold key1 150 cycles -> long event exactly 100 cycles after the press flag is sampled (+1 edge of latency), evt_long=1, led[1] toggles every 10 cycles; release -> no event. Second long press -> blink off, led[1]=level[1]=0.
- Contention: ptr=1, release flags for keys 0, 2 and 3 on the same cycle (all in HELD) -> evt_key sequence 2, 3, 0 on three consecutive cycles; final ptr=1.
- Ignored inputs: release flag on a key in IDLE, press flag on a key in HELD -> no evt_valid, FSM state unchanged.
- Same-edge overwrite: key2 pending, and a new event for key2 posts on its grant edge -> pend[2] remains 1 with the new type; served next.
- Reset mid-hold: key3 held 60 cycles, then rst_n low -> led=0 and evt_valid=0 immediately without a clock edge. After rst_n high with key3 still held and no new flag: no long event; the later release flag is ignored.
